// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, talks to imem over req/ack.
// Optional build macro FETCH_PERF_CNT_EN adds fetch and stall performance counters.
module fetch_stage #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DAT_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [DAT_WIDTH-1:0]  NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  PC_Write,
   input  logic                  IF_ID_Write,
   input  logic                  PCSrc_E,
   input  logic [ADDR_WIDTH-1:0] PC_Target_E,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DAT_WIDTH-1:0]  imem_rdata,
   output logic [DAT_WIDTH-1:0]  Ins_D,
   output logic [ADDR_WIDTH-1:0] PC_D,
   output logic [ADDR_WIDTH-1:0] PC_4D,
   output logic                  Valid_D
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   // state | meaning
   // IDLE  | one cycle after reset release, no request yet
   // REQ   | request for pc outstanding
   // HOLD  | response parked in skid buffer while downstream stalls
   // DROP  | request for a squashed address outstanding; its data is discarded

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pending;
   logic [ADDR_WIDTH-1:0] skid_pc;
   logic [DAT_WIDTH-1:0]  skid_ins;
   logic                  adv;
   logic [ADDR_WIDTH-1:0] pc_next4;
   logic [ADDR_WIDTH-1:0] target;
   logic                  unused_tgt;

   assign adv        = PC_Write & IF_ID_Write;
   assign pc_next4   = pc + ADDR_WIDTH'(4);
   assign target     = {PC_Target_E[ADDR_WIDTH-1:2], 2'b00};
   assign unused_tgt = ^PC_Target_E[1:0];
   // pc is frozen in DROP, so it still carries the stale address the handshake must hold
   assign imem_addr  = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         pending  <= '0;
         skid_pc  <= '0;
         skid_ins <= '0;
         imem_req <= 1'b0;
         Ins_D    <= NOP_INSTR;
         PC_D     <= '0;
         PC_4D    <= '0;
         Valid_D  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               if (PCSrc_E) begin
                  Ins_D   <= NOP_INSTR;
                  Valid_D <= 1'b0;
                  if (imem_ack) begin
                     pc <= target;
                  end else begin
                     pending <= target;
                     state   <= DROP;
                  end
               end else if (imem_ack) begin
                  if (adv) begin
                     Ins_D   <= imem_rdata;
                     PC_D    <= pc;
                     PC_4D   <= pc_next4;
                     Valid_D <= 1'b1;
                     pc      <= pc_next4;
                  end else begin
                     skid_ins <= imem_rdata;
                     skid_pc  <= pc;
                     state    <= HOLD;
                     imem_req <= 1'b0;
                  end
               end else if (IF_ID_Write) begin
                  Ins_D   <= NOP_INSTR;
                  Valid_D <= 1'b0;
               end
            end
            HOLD: begin
               if (PCSrc_E) begin
                  Ins_D    <= NOP_INSTR;
                  Valid_D  <= 1'b0;
                  pc       <= target;
                  state    <= REQ;
                  imem_req <= 1'b1;
               end else if (adv) begin
                  Ins_D    <= skid_ins;
                  PC_D     <= skid_pc;
                  PC_4D    <= pc_next4;
                  Valid_D  <= 1'b1;
                  pc       <= pc_next4;
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            end
            DROP: begin
               if (PCSrc_E || IF_ID_Write) begin
                  Ins_D   <= NOP_INSTR;
                  Valid_D <= 1'b0;
               end
               // a redirect arriving with the stale ack wins over the older pending target
               if (imem_ack) begin
                  pc    <= PCSrc_E ? target : pending;
                  state <= REQ;
               end else if (PCSrc_E) begin
                  pending <= target;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetch_load;
   logic stall_cyc;

   assign fetch_load = !PCSrc_E && adv && ((state == REQ && imem_ack) || state == HOLD);
   assign stall_cyc  = (state == REQ && !imem_ack) || state == HOLD || state == DROP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (fetch_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (stall_cyc)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule
